pixel_scan_controller: RTL and testbench

Frame-scan sequencer for the per-pixel colour classifier in the laser projector. It walks the 9-bit RGB333 frame buffer in raster order and feeds each pixel to the combinational classifier. It accumulates, per colour, the pixel count and the x/y coordinate sums of qualifying pixels. At frame end it publishes those totals so downstream logic can compute red/green/blue blob centroids.

---
 rtl/pixel_scan_controller.sv | 220 ++++++++++++++++++++++
 tb/tb_pixel_scan_controller.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/pixel_scan_controller.sv
// Raster-order frame-buffer scanner feeding a pixel classifier; accumulates per-colour counts and x/y sums.
// Build option: define PIXEL_SCAN_BLUE_EN to keep the blue channel, otherwise its outputs are tied to 0.
//
// state   | meaning
// IDLE    | waiting for start, accumulators and x/y cleared
// SCAN    | issuing one frame-buffer address per cycle
// DRAIN   | waiting MEM_LAT cycles for in-flight reads
// PUBLISH | results visible, done high, start accepted
module pixel_scan_controller #(
  parameter int WIDTH   = 320,
  parameter int HEIGHT  = 240,
  parameter int ADDR_W  = 17,
  parameter int X_W     = 9,
  parameter int Y_W     = 8,
  parameter int MEM_LAT = 2,
  parameter int SUM_W   = 26
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [8:0]        class_data,
  input  logic [8:0]        mem_data,
  input  logic              class_red,
  input  logic              class_green,
  input  logic              class_blue,
  output logic [ADDR_W-1:0] red_cnt,
  output logic [ADDR_W-1:0] green_cnt,
  output logic [ADDR_W-1:0] blue_cnt,
  output logic [SUM_W-1:0]  red_sum_x,
  output logic [SUM_W-1:0]  green_sum_x,
  output logic [SUM_W-1:0]  blue_sum_x,
  output logic [SUM_W-1:0]  red_sum_y,
  output logic [SUM_W-1:0]  green_sum_y,
  output logic [SUM_W-1:0]  blue_sum_y
);

`ifdef PIXEL_SCAN_BLUE_EN
  localparam int NCOL = 3;
`else
  localparam int NCOL = 2;
`endif

  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(WIDTH * HEIGHT - 1);
  localparam logic [X_W-1:0]    X_LAST     = X_W'(WIDTH - 1);
  localparam logic [2:0]        DRAIN_INIT = 3'(MEM_LAT - 1);

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, PUBLISH} state_t;

  state_t                          state_q, state_d;
  logic                            busy_q, busy_d;
  logic                            done_q, done_d;
  logic [ADDR_W-1:0]               addr_q, addr_d;
  logic [X_W-1:0]                  x_q, x_d;
  logic [Y_W-1:0]                  y_q, y_d;
  logic [2:0]                      drain_q, drain_d;
  logic                            issue;
  logic                            publish;

  logic [MEM_LAT-1:0]              vld_q;
  logic [MEM_LAT-1:0][X_W-1:0]     px_q;
  logic [MEM_LAT-1:0][Y_W-1:0]     py_q;

  logic                            qual;
  logic [NCOL-1:0]                 hit;
  logic [NCOL-1:0][ADDR_W-1:0]     cnt_q, cnt_d, ocnt_q;
  logic [NCOL-1:0][SUM_W-1:0]      sx_q, sx_d, sy_q, sy_d, osx_q, osy_q;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    x_d     = '0;
    y_d     = '0;
    drain_d = drain_q;
    issue   = 1'b0;
    publish = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SCAN;
          addr_d  = '0;
        end
      end
      SCAN: begin
        issue = 1'b1;
        if (addr_q == LAST_ADDR) begin
          state_d = DRAIN;
          drain_d = DRAIN_INIT;
        end else begin
          addr_d = addr_q + ADDR_W'(1);
          if (x_q == X_LAST) begin
            x_d = '0;
            y_d = y_q + Y_W'(1);
          end else begin
            x_d = x_q + X_W'(1);
            y_d = y_q;
          end
        end
      end
      DRAIN: begin
        if (drain_q == 3'd0) begin
          state_d = PUBLISH;
          publish = 1'b1;
        end else begin
          drain_d = drain_q - 3'd1;
        end
      end
      PUBLISH: begin
        if (start) begin
          state_d = SCAN;
          addr_d  = '0;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == SCAN) || (state_d == DRAIN);
    done_d = (state_d == PUBLISH);
  end

  // Black pixels never count, whatever the classifier says.
  assign qual = vld_q[MEM_LAT-1] && (mem_data != 9'd0);

`ifdef PIXEL_SCAN_BLUE_EN
  assign hit = {class_blue, class_green, class_red} & {NCOL{qual}};
`else
  logic unused_class_blue;
  assign unused_class_blue = class_blue;
  assign hit = {class_green, class_red} & {NCOL{qual}};
`endif

  always_comb begin
    cnt_d = cnt_q;
    sx_d  = sx_q;
    sy_d  = sy_q;
    if ((state_q == IDLE) || (state_q == PUBLISH)) begin
      cnt_d = '0;
      sx_d  = '0;
      sy_d  = '0;
    end else begin
      for (int c = 0; c < NCOL; c++) begin
        if (hit[c]) begin
          cnt_d[c] = cnt_q[c] + ADDR_W'(1);
          sx_d[c]  = sx_q[c] + SUM_W'(px_q[MEM_LAT-1]);
          sy_d[c]  = sy_q[c] + SUM_W'(py_q[MEM_LAT-1]);
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      addr_q  <= '0;
      x_q     <= '0;
      y_q     <= '0;
      drain_q <= '0;
      vld_q   <= '0;
      px_q    <= '0;
      py_q    <= '0;
      cnt_q   <= '0;
      sx_q    <= '0;
      sy_q    <= '0;
      ocnt_q  <= '0;
      osx_q   <= '0;
      osy_q   <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      addr_q  <= addr_d;
      x_q     <= x_d;
      y_q     <= y_d;
      drain_q <= drain_d;
      vld_q[0] <= issue;
      px_q[0]  <= x_q;
      py_q[0]  <= y_q;
      for (int i = 1; i < MEM_LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        px_q[i]  <= px_q[i-1];
        py_q[i]  <= py_q[i-1];
      end
      cnt_q <= cnt_d;
      sx_q  <= sx_d;
      sy_q  <= sy_d;
      // The final pixel lands on the publish edge, so latch the next-state totals.
      if (publish) begin
        ocnt_q <= cnt_d;
        osx_q  <= sx_d;
        osy_q  <= sy_d;
      end
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign mem_addr    = addr_q;
  assign class_data  = mem_data;
  assign red_cnt     = ocnt_q[0];
  assign red_sum_x   = osx_q[0];
  assign red_sum_y   = osy_q[0];
  assign green_cnt   = ocnt_q[1];
  assign green_sum_x = osx_q[1];
  assign green_sum_y = osy_q[1];
`ifdef PIXEL_SCAN_BLUE_EN
  assign blue_cnt    = ocnt_q[2];
  assign blue_sum_x  = osx_q[2];
  assign blue_sum_y  = osy_q[2];
`else
  assign blue_cnt    = '0;
  assign blue_sum_x  = '0;
  assign blue_sum_y  = '0;
`endif

endmodule

// File: tb/tb_pixel_scan_controller.sv
// Self-checking bench for pixel_scan_controller on a 4x2 frame with a 2-cycle frame-buffer model.
module tb_pixel_scan_controller;
  localparam int TB_W   = 4;
  localparam int TB_H   = 2;
  localparam int TB_ML  = 2;
  localparam int NPIX   = TB_W * TB_H;
  localparam int ADDR_W = 17;
  localparam int SUM_W  = 26;
  localparam int LAST_C = NPIX + TB_ML + 1;

  logic              clock = 1'b0;
  logic              reset_n;
  logic              start;
  logic              busy, done;
  logic [ADDR_W-1:0] mem_addr;
  logic [8:0]        class_data, mem_data;
  logic              class_red, class_green, class_blue;
  logic [ADDR_W-1:0] red_cnt, green_cnt, blue_cnt;
  logic [SUM_W-1:0]  red_sum_x, green_sum_x, blue_sum_x;
  logic [SUM_W-1:0]  red_sum_y, green_sum_y, blue_sum_y;

  int   n_checks = 0;
  int   n_errors = 0;
  bit   cls_mode = 1'b0;
  logic [8:0] fb [NPIX];
  logic [ADDR_W-1:0] ad [TB_ML];
  longint exp_cnt [3];
  longint exp_sx  [3];
  longint exp_sy  [3];

  pixel_scan_controller #(
    .WIDTH(TB_W), .HEIGHT(TB_H), .ADDR_W(ADDR_W), .X_W(9), .Y_W(8),
    .MEM_LAT(TB_ML), .SUM_W(SUM_W)
  ) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .busy(busy), .done(done),
    .mem_addr(mem_addr), .class_data(class_data), .mem_data(mem_data),
    .class_red(class_red), .class_green(class_green), .class_blue(class_blue),
    .red_cnt(red_cnt), .green_cnt(green_cnt), .blue_cnt(blue_cnt),
    .red_sum_x(red_sum_x), .green_sum_x(green_sum_x), .blue_sum_x(blue_sum_x),
    .red_sum_y(red_sum_y), .green_sum_y(green_sum_y), .blue_sum_y(blue_sum_y)
  );

  always #5 clock = ~clock;

  // Frame buffer with fixed read latency.
  always @(posedge clock) begin
    ad[0] <= mem_addr;
    for (int i = 1; i < TB_ML; i++) ad[i] <= ad[i-1];
  end
  assign mem_data = fb[ad[TB_ML-1][2:0]];

  // Mode 0: strict dominant component. Mode 1: ties qualify, so black and grey hit every colour.
  function automatic bit cls(input int c, input logic [8:0] p, input bit mode);
    int v [3];
    v[0] = int'(p[8:6]);
    v[1] = int'(p[5:3]);
    v[2] = int'(p[2:0]);
    if (mode) return (v[c] >= v[(c+1)%3]) && (v[c] >= v[(c+2)%3]);
    return (v[c] > v[(c+1)%3]) && (v[c] > v[(c+2)%3]);
  endfunction

  always_comb begin
    class_red   = cls(0, class_data, cls_mode);
    class_green = cls(1, class_data, cls_mode);
    class_blue  = cls(2, class_data, cls_mode);
  end

  task automatic check_val(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic compute_model();
    for (int c = 0; c < 3; c++) begin
      exp_cnt[c] = 0; exp_sx[c] = 0; exp_sy[c] = 0;
    end
    for (int y = 0; y < TB_H; y++)
      for (int x = 0; x < TB_W; x++) begin
        logic [8:0] p;
        p = fb[y*TB_W + x];
        if (p != 9'd0)
          for (int c = 0; c < 3; c++)
            if (cls(c, p, cls_mode)) begin
              exp_cnt[c]++; exp_sx[c] += x; exp_sy[c] += y;
            end
      end
`ifndef PIXEL_SCAN_BLUE_EN
    exp_cnt[2] = 0; exp_sx[2] = 0; exp_sy[2] = 0;
`endif
  endtask

  task automatic check_results(input string tag);
    check_val({tag, "_red_cnt"},   red_cnt,     exp_cnt[0]);
    check_val({tag, "_red_sx"},    red_sum_x,   exp_sx[0]);
    check_val({tag, "_red_sy"},    red_sum_y,   exp_sy[0]);
    check_val({tag, "_green_cnt"}, green_cnt,   exp_cnt[1]);
    check_val({tag, "_green_sx"},  green_sum_x, exp_sx[1]);
    check_val({tag, "_green_sy"},  green_sum_y, exp_sy[1]);
    check_val({tag, "_blue_cnt"},  blue_cnt,    exp_cnt[2]);
    check_val({tag, "_blue_sx"},   blue_sum_x,  exp_sx[2]);
    check_val({tag, "_blue_sy"},   blue_sum_y,  exp_sy[2]);
  endtask

  // Cycle c is the interval after edge c-1; start is sampled at edge 0.
  task automatic run_scan(input string tag, input bit pre_started, input bit inject_mid,
                          input bit chain_next);
    compute_model();
    if (!pre_started) begin
      @(negedge clock);
      start = 1'b1;
    end
    @(posedge clock);
    #1 start = 1'b0;
    for (int c = 1; c <= LAST_C; c++) begin
      @(negedge clock);
      check_val({tag, "_busy"}, busy, (c <= NPIX + TB_ML) ? 1 : 0);
      check_val({tag, "_done"}, done, (c == LAST_C) ? 1 : 0);
      check_val({tag, "_addr"}, mem_addr, (c <= NPIX) ? c - 1 : NPIX - 1);
      check_val({tag, "_cdata"}, class_data, mem_data);
      if (inject_mid && c == 5) start = 1'b1;
      if (inject_mid && c == 6) start = 1'b0;
    end
    check_results(tag);
    if (chain_next) start = 1'b1;
  endtask

  task automatic fill_frame(input logic [8:0] v);
    for (int i = 0; i < NPIX; i++) fb[i] = v;
  endtask

  initial begin
    bit chain, prev_chain;
    reset_n = 1'b0;
    start   = 1'b0;
    fill_frame(9'd0);
    #12;
    check_val("rst_busy", busy, 0);
    check_val("rst_done", done, 0);
    check_val("rst_addr", mem_addr, 0);
    check_val("rst_red_cnt", red_cnt, 0);
    @(negedge clock);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);

    // All-zero frame.
    run_scan("zero", 1'b0, 1'b0, 1'b0);

    // Single red pixel at (3,1); results must then hold in IDLE.
    fill_frame(9'd0);
    fb[1*TB_W + 3] = 9'b111_000_000;
    run_scan("red1", 1'b0, 1'b0, 1'b0);
    check_val("red1_cnt_k", red_cnt, 1);
    check_val("red1_sx_k", red_sum_x, 3);
    check_val("red1_sy_k", red_sum_y, 1);
    check_val("red1_gcnt_k", green_cnt, 0);
    repeat (3) @(negedge clock);
    check_val("hold_busy", busy, 0);
    check_val("hold_addr", mem_addr, NPIX - 1);
    check_results("hold");

    // All green; a mid-scan start is ignored and a start on done chains the next scan.
    fill_frame(9'b000_111_000);
    run_scan("green", 1'b0, 1'b1, 1'b1);
    check_val("green_cnt_k", green_cnt, 8);
    check_val("green_sx_k", green_sum_x, 12);
    check_val("green_sy_k", green_sum_y, 4);
    fill_frame(9'd0);
    fb[0*TB_W + 1] = 9'b000_000_111;
    run_scan("blue", 1'b1, 1'b0, 1'b0);
`ifdef PIXEL_SCAN_BLUE_EN
    check_val("blue_cnt_k", blue_cnt, 1);
    check_val("blue_sx_k", blue_sum_x, 1);
`else
    check_val("blue_cnt_k", blue_cnt, 0);
    check_val("blue_sx_k", blue_sum_x, 0);
`endif

    // Asynchronous reset mid-scan, after nonzero results are published.
    fill_frame(9'b111_000_000);
    run_scan("pre_rst", 1'b0, 1'b0, 1'b0);
    @(negedge clock);
    start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    repeat (6) @(negedge clock);
    reset_n = 1'b0;
    #1;
    check_val("mrst_busy", busy, 0);
    check_val("mrst_done", done, 0);
    check_val("mrst_addr", mem_addr, 0);
    check_val("mrst_red_cnt", red_cnt, 0);
    check_val("mrst_red_sx", red_sum_x, 0);
    check_val("mrst_red_sy", red_sum_y, 0);
    @(negedge clock);
    reset_n = 1'b1;
    fb[2] = 9'b010_110_001;
    run_scan("post_rst", 1'b0, 1'b0, 1'b0);

    // Random frames and classifier modes, some scans chained back to back.
    prev_chain = 1'b0;
    for (int r = 0; r < 10; r++) begin
      for (int i = 0; i < NPIX; i++)
        fb[i] = ($urandom_range(0, 3) == 0) ? 9'd0 : 9'($urandom_range(0, 511));
      cls_mode = 1'($urandom_range(0, 1));
      chain = (r < 9) ? 1'($urandom_range(0, 1)) : 1'b0;
      run_scan($sformatf("rnd%0d", r), prev_chain, 1'b0, chain);
      prev_chain = chain;
    end

    repeat (2) @(negedge clock);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
